// File: rtl/button_debouncer.sv
// Per-key synchronise + debounce for the board push-buttons.
// Drives the core's 32-bit button word with levels and a press counter.
module button_debouncer #(
  parameter int N_BUTTONS       = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic                 clk_clk,
  input  logic                 reset_reset,
  input  logic [N_BUTTONS-1:0] key_raw,
  output logic [31:0]          button_export,
  output logic [N_BUTTONS-1:0] press_pulse,
  output logic [N_BUTTONS-1:0] release_pulse
);

  localparam int CW =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST =
    CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [N_BUTTONS-1:0] REL =
    ACTIVE_LOW ? '1 : '0;

  logic [N_BUTTONS-1:0] s1;
  logic [N_BUTTONS-1:0] s2;
  logic [N_BUTTONS-1:0] p;
  logic [N_BUTTONS-1:0] st;
  logic [N_BUTTONS-1:0] st_nxt;
  logic [N_BUTTONS-1:0] prs_nxt;
  logic [N_BUTTONS-1:0] rel_nxt;
  logic [CW-1:0]        cnt     [N_BUTTONS];
  logic [CW-1:0]        cnt_nxt [N_BUTTONS];
  logic [7:0]           press_cnt;

  assign p = ACTIVE_LOW ? ~s2 : s2;

  // A channel is pending whenever p differs from st
  always_comb begin
    st_nxt  = st;
    prs_nxt = '0;
    rel_nxt = '0;
    for (int i = 0; i < N_BUTTONS; i++) begin
      cnt_nxt[i] = '0;
      if (p[i] != st[i]) begin
        if (cnt[i] == LAST) begin
          st_nxt[i]  = p[i];
          prs_nxt[i] = p[i];
          rel_nxt[i] = ~p[i];
        end else begin
          cnt_nxt[i] = cnt[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      s1            <= REL;
      s2            <= REL;
      st            <= '0;
      press_pulse   <= '0;
      release_pulse <= '0;
      press_cnt     <= '0;
      for (int i = 0; i < N_BUTTONS; i++)
        cnt[i] <= '0;
    end else begin
      s1            <= key_raw;
      s2            <= s1;
      st            <= st_nxt;
      press_pulse   <= prs_nxt;
      release_pulse <= rel_nxt;
      press_cnt     <= press_cnt + 8'(|press_pulse);
      for (int i = 0; i < N_BUTTONS; i++)
        cnt[i] <= cnt_nxt[i];
    end
  end

  // Counter advances the cycle after a pulse is visible
  assign button_export =
    {16'h0, press_cnt, 8'(st)};

endmodule

// File: tb/tb_button_debouncer.sv
// Randomised and directed bench for button_debouncer
// against a sample-history reference model.
module tb_button_debouncer;

  localparam int N = 4;
  localparam int D = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] key_raw;
  logic [31:0]  button_export;
  logic [N-1:0] pp;
  logic [N-1:0] rp;

  always #5 clk = ~clk;

  button_debouncer #(
    .N_BUTTONS      (N),
    .DEBOUNCE_CYCLES(D),
    .ACTIVE_LOW     (1'b1)
  ) dut (
    .clk_clk      (clk),
    .reset_reset  (rst),
    .key_raw      (key_raw),
    .button_export(button_export),
    .press_pulse  (pp),
    .release_pulse(rp)
  );

  int n_vec = 0;
  int n_err = 0;
  int pp2_seen = 0;
  int rp0_seen = 0;

  logic [N-1:0] r1 = '1;
  logic [N-1:0] r2 = '1;
  logic [N-1:0] m_st = '0;
  logic [N-1:0] m_pp = '0;
  logic [N-1:0] m_rp = '0;
  logic [7:0]   m_pc = '0;
  logic [D-1:0] ph [N];

  task automatic chk(string nm,
                     logic [31:0] got,
                     logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h",
               nm, got, exp);
    end
  endtask

  // A key level is accepted once the last D pressed-flags
  // seen by the channel all disagree with its stable level.
  always @(posedge clk) begin : model
    logic [N-1:0] kr;
    logic [N-1:0] pn;
    logic         rr;
    kr = key_raw;
    rr = rst;
    if (rr) begin
      r1 = '1;
      r2 = '1;
      m_st = '0;
      m_pp = '0;
      m_rp = '0;
      m_pc = '0;
      for (int c = 0; c < N; c++) ph[c] = '0;
    end else begin
      if (|m_pp) m_pc = m_pc + 8'd1;
      pn = ~r2;
      r2 = r1;
      r1 = kr;
      m_pp = '0;
      m_rp = '0;
      for (int c = 0; c < N; c++) begin
        ph[c] = {ph[c][D-2:0], pn[c]};
        if (ph[c] == {D{~m_st[c]}}) begin
          m_st[c] = ~m_st[c];
          if (m_st[c]) m_pp[c] = 1'b1;
          else m_rp[c] = 1'b1;
        end
      end
    end
    #1;
    chk("export", button_export,
        {16'h0, m_pc, 4'h0, m_st});
    chk("press", 32'(pp), 32'(m_pp));
    chk("release", 32'(rp), 32'(m_rp));
    if (pp[2]) pp2_seen++;
    if (rp[0]) rp0_seen++;
  end

  task automatic nd(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    nd(2);
    rst = 1'b0;
    nd(3);
  endtask

  int base;
  int hold [N];

  initial begin
    rst = 1'b1;
    key_raw = '1;
    nd(3);
    chk("reset_export", button_export, 32'h0);
    chk("reset_press", 32'(pp), 32'h0);
    rst = 1'b0;
    nd(3);

    // single press on key 0
    key_raw[0] = 1'b0;
    nd(9);
    chk("k0_early", button_export, 32'h0);
    nd(1);
    chk("k0_export", button_export, 32'h1);
    chk("k0_pulse", 32'(pp), 32'h1);
    nd(1);
    chk("k0_pulse_end", 32'(pp), 32'h0);
    chk("k0_cnt", button_export, 32'h101);

    // short glitch on key 1
    key_raw[1] = 1'b0;
    nd(5);
    key_raw[1] = 1'b1;
    nd(20);
    chk("glitch_export", button_export, 32'h101);

    // bounce on key 2, then hold
    base = pp2_seen;
    for (int s = 0; s < 10; s++) begin
      key_raw[2] = s[0];
      nd(3);
    end
    key_raw[2] = 1'b0;
    nd(9);
    chk("bounce_early", 32'(pp), 32'h0);
    nd(1);
    chk("bounce_pulse", 32'(pp), 32'h4);
    nd(5);
    chk("bounce_count", 32'(pp2_seen - base), 32'd1);

    // simultaneous press of keys 0 and 3
    key_raw = '1;
    do_reset();
    key_raw = 4'b0110;
    nd(10);
    chk("dual_pulse", 32'(pp), 32'h9);
    chk("dual_export", button_export, 32'h9);
    nd(1);
    chk("dual_cnt", button_export, 32'h109);

    // press counter wrap
    key_raw = '1;
    do_reset();
    base = rp0_seen;
    for (int i = 0; i < 256; i++) begin
      key_raw[0] = 1'b0;
      nd(12);
      key_raw[0] = 1'b1;
      nd(12);
    end
    chk("wrap_export", button_export, 32'h0);
    chk("wrap_rel", 32'(rp0_seen - base), 32'd256);

    // reset in the middle of a pending press
    key_raw[0] = 1'b0;
    nd(12);
    key_raw[1] = 1'b0;
    nd(6);
    rst = 1'b1;
    nd(1);
    chk("midrst_export", button_export, 32'h0);
    chk("midrst_press", 32'(pp), 32'h0);
    nd(2);
    rst = 1'b0;
    nd(9);
    chk("rerun_early", 32'(pp), 32'h0);
    nd(1);
    chk("rerun_pulse", 32'(pp), 32'h3);
    chk("rerun_export", button_export, 32'h3);
    nd(1);
    chk("rerun_cnt", button_export, 32'h103);

    // random keys with occasional reset
    for (int c = 0; c < N; c++) hold[c] = 0;
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      for (int c = 0; c < N; c++) begin
        if (hold[c] == 0) begin
          key_raw[c] = ~key_raw[c];
          hold[c] = $urandom_range(1, 20);
        end else begin
          hold[c]--;
        end
      end
      rst = ($urandom_range(0, 499) == 0);
    end
    rst = 1'b0;
    nd(4);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
